// File: rtl/lcbbc_sweep_ctrl.sv
// Sweeps one lcbbc search engine over a range of min-HD values and reports the code count of each run.
// Optional watchdog abort per run is enabled by defining LCBBC_SWEEP_TIMEOUT_EN.
module lcbbc_sweep_ctrl #(
    parameter int N       = 3,
    parameter int HD_W    = 2,
    parameter int CNT_W   = 10,
    parameter int TIMEOUT = 65535
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [HD_W-1:0]  i_hd_lo,
    input  logic [HD_W-1:0]  i_hd_hi,
    output logic             o_eng_start,
    output logic [HD_W-1:0]  o_eng_min_hd,
    input  logic             i_eng_code_valid,
    input  logic [N-1:0]     i_eng_code,
    input  logic             i_eng_done,
    output logic             o_eng_abort,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [HD_W-1:0]  o_res_min_hd,
    output logic [CNT_W-1:0] o_res_count,
    output logic             o_res_timeout,
    output logic             o_busy,
    output logic             o_sweep_done,
    output logic             o_cfg_err,
    output logic [HD_W-1:0]  o_best_hd,
    output logic [CNT_W-1:0] o_best_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_REPORT,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [HD_W-1:0]  r_cur_hd;
    logic [HD_W-1:0]  r_hd_hi;
    logic [CNT_W-1:0] r_cnt;
    logic             r_eng_start;
    logic             r_res_valid;
    logic [HD_W-1:0]  r_res_min_hd;
    logic [CNT_W-1:0] r_res_count;
    logic             r_busy;
    logic             r_sweep_done;
    logic             r_cfg_err;
    logic [HD_W-1:0]  r_best_hd;
    logic [CNT_W-1:0] r_best_count;

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_best_upd;
    logic             w_unused;

    // Saturating count including the code presented this cycle, so a code that arrives with done is kept.
    assign w_cnt_next = (i_eng_code_valid && (r_cnt != {CNT_W{1'b1}})) ? r_cnt + 1'b1 : r_cnt;

    // Codes are only counted; their values and the watchdog limit are not otherwise needed here.
    assign w_unused = (^i_eng_code) ^ (TIMEOUT == 0);

`ifdef LCBBC_SWEEP_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] r_wd;
    logic            r_eng_abort;
    logic            r_res_timeout;

    assign o_eng_abort   = r_eng_abort;
    assign o_res_timeout = r_res_timeout;
    assign w_best_upd    = !r_res_timeout && (r_res_count > r_best_count);
`else
    assign o_eng_abort   = 1'b0;
    assign o_res_timeout = 1'b0;
    assign w_best_upd    = (r_res_count > r_best_count);
`endif

    assign o_eng_start  = r_eng_start;
    assign o_eng_min_hd = r_cur_hd;
    assign o_res_valid  = r_res_valid;
    assign o_res_min_hd = r_res_min_hd;
    assign o_res_count  = r_res_count;
    assign o_busy       = r_busy;
    assign o_sweep_done = r_sweep_done;
    assign o_cfg_err    = r_cfg_err;
    assign o_best_hd    = r_best_hd;
    assign o_best_count = r_best_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_cur_hd     <= '0;
            r_hd_hi      <= '0;
            r_cnt        <= '0;
            r_eng_start  <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_min_hd <= '0;
            r_res_count  <= '0;
            r_busy       <= 1'b0;
            r_sweep_done <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_best_hd    <= '0;
            r_best_count <= '0;
`ifdef LCBBC_SWEEP_TIMEOUT_EN
            r_wd          <= '0;
            r_eng_abort   <= 1'b0;
            r_res_timeout <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if (i_hd_lo <= i_hd_hi) begin
                            r_hd_hi      <= i_hd_hi;
                            r_cur_hd     <= i_hd_lo;
                            r_best_hd    <= '0;
                            r_best_count <= '0;
                            r_cfg_err    <= 1'b0;
                            r_busy       <= 1'b1;
                            r_eng_start  <= 1'b1;
                            r_state      <= S_LAUNCH;
                        end else begin
                            r_cfg_err <= 1'b1;
                        end
                    end
                end

                S_LAUNCH: begin
                    r_eng_start <= 1'b0;
                    r_cnt       <= '0;
`ifdef LCBBC_SWEEP_TIMEOUT_EN
                    // Watchdog holds the number of cycles elapsed since the launch pulse.
                    r_wd        <= WD_W'(1);
`endif
                    r_state     <= S_RUN;
                end

                S_RUN: begin
                    r_cnt <= w_cnt_next;
                    if (i_eng_done) begin
                        r_res_min_hd <= r_cur_hd;
                        r_res_count  <= w_cnt_next;
                        r_res_valid  <= 1'b1;
`ifdef LCBBC_SWEEP_TIMEOUT_EN
                        r_res_timeout <= 1'b0;
`endif
                        r_state      <= S_REPORT;
                    end
`ifdef LCBBC_SWEEP_TIMEOUT_EN
                    else if (r_wd == WD_W'(TIMEOUT - 1)) begin
                        r_res_min_hd  <= r_cur_hd;
                        r_res_count   <= w_cnt_next;
                        r_res_valid   <= 1'b1;
                        r_res_timeout <= 1'b1;
                        r_eng_abort   <= 1'b1;
                        r_state       <= S_REPORT;
                    end else begin
                        r_wd <= r_wd + 1'b1;
                    end
`endif
                end

                S_REPORT: begin
`ifdef LCBBC_SWEEP_TIMEOUT_EN
                    r_eng_abort <= 1'b0;
`endif
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_best_upd) begin
                            r_best_hd    <= r_res_min_hd;
                            r_best_count <= r_res_count;
                        end
                        // Compare before incrementing so the top HD value ends the sweep instead of wrapping.
                        if (r_cur_hd == r_hd_hi) begin
                            r_sweep_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else begin
                            r_cur_hd    <= r_cur_hd + 1'b1;
                            r_eng_start <= 1'b1;
                            r_state     <= S_LAUNCH;
                        end
                    end
                end

                S_DONE: begin
                    r_sweep_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcbbc_sweep_ctrl.sv
// Scoreboard bench for lcbbc_sweep_ctrl: a scripted engine model emits codes, a monitor checks each record.
// The watchdog scenario is exercised only when LCBBC_SWEEP_TIMEOUT_EN is defined.
module tb_lcbbc_sweep_ctrl;

    localparam int N       = 3;
    localparam int HD_W    = 2;
    localparam int CNT_W   = 10;
    localparam int TIMEOUT = 20;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int hd;
        int k;
        int gapMax;
        bit doneWithLast;
        bit noDone;
    } plan_t;

    typedef struct {
        int hd;
        int count;
        bit timeout;
    } rec_t;

    logic             i_clk;
    logic             i_rst;
    logic             i_start;
    logic [HD_W-1:0]  i_hd_lo;
    logic [HD_W-1:0]  i_hd_hi;
    logic             o_eng_start;
    logic [HD_W-1:0]  o_eng_min_hd;
    logic             i_eng_code_valid;
    logic [N-1:0]     i_eng_code;
    logic             i_eng_done;
    logic             o_eng_abort;
    logic             o_res_valid;
    logic             i_res_ready;
    logic [HD_W-1:0]  o_res_min_hd;
    logic [CNT_W-1:0] o_res_count;
    logic             o_res_timeout;
    logic             o_busy;
    logic             o_sweep_done;
    logic             o_cfg_err;
    logic [HD_W-1:0]  o_best_hd;
    logic [CNT_W-1:0] o_best_count;

    lcbbc_sweep_ctrl #(
        .N(N), .HD_W(HD_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_hd_lo(i_hd_lo), .i_hd_hi(i_hd_hi),
        .o_eng_start(o_eng_start), .o_eng_min_hd(o_eng_min_hd),
        .i_eng_code_valid(i_eng_code_valid), .i_eng_code(i_eng_code),
        .i_eng_done(i_eng_done), .o_eng_abort(o_eng_abort),
        .o_res_valid(o_res_valid), .i_res_ready(i_res_ready),
        .o_res_min_hd(o_res_min_hd), .o_res_count(o_res_count),
        .o_res_timeout(o_res_timeout), .o_busy(o_busy),
        .o_sweep_done(o_sweep_done), .o_cfg_err(o_cfg_err),
        .o_best_hd(o_best_hd), .o_best_count(o_best_count)
    );

    int    checks = 0;
    int    errors = 0;
    int    cycleCount = 0;
    int    lastStartCycle = 0;
    int    sweepDoneCount = 0;
    int    abortCount = 0;
    int    expSweeps = 0;
    int    expAborts = 0;
    int    refBestHd = 0;
    int    refBestCount = 0;
    bit    readyHold = 0;
    bit    readyRandom = 0;
    bit    engAborted = 0;
    plan_t planQ[$];
    rec_t  expQ[$];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Schedules one engine run; the expected record follows from the spec rules (saturating count).
    task automatic pushRun(input int hd, input int k, input int gapMax, input bit dwl,
                           input bit noDone, input bit expectRec);
        plan_t p;
        rec_t  r;
        p.hd = hd; p.k = k; p.gapMax = gapMax; p.doneWithLast = dwl; p.noDone = noDone;
        planQ.push_back(p);
        if (expectRec) begin
            r.hd = hd; r.count = (k > CNT_MAX) ? CNT_MAX : k; r.timeout = noDone;
            expQ.push_back(r);
        end
    endtask

    task automatic applyStimulus(input int lo, input int hi);
        @(posedge i_clk); #1;
        i_start = 1'b1;
        i_hd_lo = HD_W'(lo);
        i_hd_hi = HD_W'(hi);
        if (lo <= hi) begin
            refBestHd    = 0;
            refBestCount = 0;
            expSweeps++;
        end
        @(posedge i_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic waitSweep(input int budget);
        int startCnt;
        startCnt = sweepDoneCount;
        for (int c = 0; c < budget; c++) begin
            @(negedge i_clk);
            if (sweepDoneCount > startCnt) return;
        end
        checkOutput("sweep_done_timeout", sweepDoneCount, startCnt + 1);
    endtask

    task automatic engCycle(input bit v, input bit d);
        @(posedge i_clk); #2;
        if (i_rst) engAborted = 1'b1;
        i_eng_code_valid = v && !engAborted;
        i_eng_done       = d && !engAborted;
        i_eng_code       = N'($urandom);
    endtask

    task automatic runEngine(input plan_t p);
        engAborted = 1'b0;
        for (int i = 0; i < p.k; i++) begin
            repeat ($urandom_range(p.gapMax, 0)) engCycle(1'b0, 1'b0);
            engCycle(1'b1, (i == p.k - 1) && p.doneWithLast && !p.noDone);
        end
        if (!p.noDone && !(p.k > 0 && p.doneWithLast)) engCycle(1'b0, 1'b1);
        engCycle(1'b0, 1'b0);
    endtask

    // Engine model: answers each launch with the next scheduled run.
    initial begin
        plan_t p;
        i_eng_code_valid = 1'b0;
        i_eng_done       = 1'b0;
        i_eng_code       = '0;
        forever begin
            @(negedge i_clk);
            if (o_eng_start && !i_rst) begin
                if (planQ.size() == 0) begin
                    checkOutput("unexpected_eng_start_hd", int'(o_eng_min_hd), -1);
                end else begin
                    p = planQ.pop_front();
                    checkOutput("eng_min_hd", int'(o_eng_min_hd), p.hd);
                    runEngine(p);
                end
            end
        end
    end

    initial begin
        i_res_ready = 1'b0;
        forever begin
            @(posedge i_clk); #1;
            i_res_ready = readyHold ? 1'b0 : (readyRandom ? 1'($urandom_range(1, 0)) : 1'b1);
        end
    end

    // Monitor: every presented record is compared against the head of the queue until it is accepted.
    initial begin
        rec_t e;
        forever begin
            @(negedge i_clk);
            if (o_eng_start) lastStartCycle = cycleCount;
            if (o_eng_abort) begin
                abortCount++;
                checkOutput("abort_delay", cycleCount - lastStartCycle, TIMEOUT);
            end
            if (o_res_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_record_count", int'(o_res_count), -1);
                end else begin
                    e = expQ[0];
                    checkOutput("res_min_hd", int'(o_res_min_hd), e.hd);
                    checkOutput("res_count", int'(o_res_count), e.count);
                    checkOutput("res_timeout", int'(o_res_timeout), int'(e.timeout));
                    if (i_res_ready) begin
                        void'(expQ.pop_front());
                        if (!e.timeout && e.count > refBestCount) begin
                            refBestHd    = e.hd;
                            refBestCount = e.count;
                        end
                    end
                end
            end
            if (o_sweep_done) begin
                sweepDoneCount++;
                checkOutput("best_hd", int'(o_best_hd), refBestHd);
                checkOutput("best_count", int'(o_best_count), refBestCount);
            end
        end
    end

    initial begin
        int lo;
        int hi;
        int bigRun;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_hd_lo = '0;
        i_hd_hi = '0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("rst_busy", int'(o_busy), 0);
        checkOutput("rst_res_valid", int'(o_res_valid), 0);
        checkOutput("rst_eng_start", int'(o_eng_start), 0);
        checkOutput("rst_eng_abort", int'(o_eng_abort), 0);
        checkOutput("rst_cfg_err", int'(o_cfg_err), 0);
        checkOutput("rst_sweep_done", int'(o_sweep_done), 0);
        checkOutput("rst_best_count", int'(o_best_count), 0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;

        // Two distances, strict-max best and start-to-launch latency.
        pushRun(1, 4, 0, 1'b0, 1'b0, 1'b1);
        pushRun(2, 2, 1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1, 2);
        @(negedge i_clk);
        checkOutput("busy_latency", int'(o_busy), 1);
        checkOutput("eng_start_latency", int'(o_eng_start), 1);
        waitSweep(200);
        checkOutput("basic_best_hd", int'(o_best_hd), 1);
        checkOutput("basic_best_count", int'(o_best_count), 4);

        // Reset in the middle of a run after three codes.
        pushRun(1, 10, 0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1, 1);
        repeat (4) @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        checkOutput("midrst_busy", int'(o_busy), 0);
        checkOutput("midrst_res_valid", int'(o_res_valid), 0);
        checkOutput("midrst_eng_min_hd", int'(o_eng_min_hd), 0);
        checkOutput("midrst_res_count", int'(o_res_count), 0);
        checkOutput("midrst_best_hd", int'(o_best_hd), 0);
        checkOutput("midrst_best_count", int'(o_best_count), 0);
        expSweeps--;
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        repeat (14) @(posedge i_clk);

        // Top HD value with downstream stalled for five cycles.
        readyHold = 1'b1;
        pushRun(3, int'($urandom_range(8, 1)), 1, 1'($urandom_range(1, 0)), 1'b0, 1'b1);
        applyStimulus(3, 3);
        for (int c = 0; c < 100 && !o_res_valid; c++) @(negedge i_clk);
        checkOutput("stall_res_valid_seen", int'(o_res_valid), 1);
        repeat (5) @(negedge i_clk);
        readyHold = 1'b0;
        waitSweep(100);
        repeat (5) @(negedge i_clk);
        checkOutput("stall_idle_busy", int'(o_busy), 0);

        // Reversed bounds flag an error without launching; the next good start clears it.
        applyStimulus(2, 1);
        @(negedge i_clk);
        checkOutput("cfg_err_set", int'(o_cfg_err), 1);
        checkOutput("cfg_err_busy", int'(o_busy), 0);
        repeat (4) begin
            @(negedge i_clk);
            checkOutput("cfg_err_no_launch", int'(o_eng_start), 0);
        end
        pushRun(0, 3, 1, 1'b1, 1'b0, 1'b1);
        applyStimulus(0, 0);
        @(negedge i_clk);
        checkOutput("cfg_err_cleared", int'(o_cfg_err), 0);
        waitSweep(100);

        // Code with done in the same cycle, and counter saturation.
`ifdef LCBBC_SWEEP_TIMEOUT_EN
        bigRun = 10;
`else
        bigRun = 1100;
`endif
        pushRun(0, 7, 1, 1'b1, 1'b0, 1'b1);
        pushRun(1, bigRun, 0, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 1);
        waitSweep(3000);
        checkOutput("sat_best_count", int'(o_best_count), (bigRun > CNT_MAX) ? CNT_MAX : bigRun);

        // Randomised sweeps with random backpressure.
        readyRandom = 1'b1;
        repeat (6) begin
            lo = int'($urandom_range(3, 0));
            hi = int'($urandom_range(3, lo));
            for (int h = lo; h <= hi; h++)
                pushRun(h, int'($urandom_range(8, 0)), 1, 1'($urandom_range(1, 0)), 1'b0, 1'b1);
            applyStimulus(lo, hi);
            waitSweep(2000);
        end
        readyRandom = 1'b0;

`ifdef LCBBC_SWEEP_TIMEOUT_EN
        // Silent engine after two codes: watchdog abort, record flagged, best untouched.
        pushRun(2, 5, 0, 1'b0, 1'b0, 1'b1);
        pushRun(3, 2, 0, 1'b0, 1'b1, 1'b1);
        expAborts++;
        applyStimulus(2, 3);
        waitSweep(200);
        checkOutput("timeout_best_hd", int'(o_best_hd), 2);
        checkOutput("timeout_best_count", int'(o_best_count), 5);
`endif

        repeat (5) @(negedge i_clk);
        checkOutput("sweep_done_total", sweepDoneCount, expSweeps);
        checkOutput("abort_total", abortCount, expAborts);
        checkOutput("records_left", expQ.size(), 0);
        checkOutput("runs_left", planQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
